uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmit FIFO between several byte-stream requesters, such as the CPU bus bridge and the debug monitor. It sits directly in front of the TX FIFO write port and grants exclusive ownership for one packet at a time, up to a burst limit. Bytes from different packets never interleave inside the FIFO.

## Interface
- N_REQ, 2: number of requesters, 2..8
- B, 8: data width, equal to the FIFO B
- MAX_BURST, 16: maximum bytes per grant before a forced release, 1..256
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  requester i has a byte on its data slice
- req_data  in  N_REQ*B  packed bytes; requester i uses bits [i*B +: B]
- req_last  in  N_REQ  the byte on requester i is the last byte of its packet
- req_ready  out  N_REQ  byte from requester i is accepted this cycle
- grant  out  N_REQ  one-hot registered owner; all zeros when idle
- fifo_wr  out  1  write strobe to the FIFO
- fifo_w_data  out  B  byte to the FIFO
- fifo_full  in  1  FIFO full flag

## Operation
- The arbiter has two states, IDLE and OWN. Reset state is IDLE, with grant=0, rr_ptr=0 and burst_cnt=0.
- **IDLE:** if any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping modulo N_REQ. Register grant as one-hot, clear burst_cnt, and move to OWN. If no req_valid is set, stay in IDLE.
- **OWN (owner g):**
  - Transfer condition: req_valid[g] & ~fifo_full.
  - When the transfer condition holds: req_ready[g]=1, fifo_wr=1, fifo_w_data equals slice g, and burst_cnt increments.
  - Release: a transfer with req_last[g]=1, or a transfer that brings burst_cnt to MAX_BURST.
  - On release: go to IDLE, grant=0, rr_ptr=(g+1) mod N_REQ.
  - If req_valid[g] is low, or fifo_full is high, hold ownership indefinitely with no transfer. There is no timeout.
- req_ready, fifo_wr and fifo_w_data are combinational from grant, req_valid, req_data and fifo_full. No other input path reaches them.
- req_ready of non-owners is always 0. fifo_w_data is 0 whenever fifo_wr=0.
- burst_cnt is wide enough to hold MAX_BURST, i.e. $clog2(MAX_BURST+1) bits. It never wraps, because reaching MAX_BURST forces a release.
- A forced release with req_last=0 leaves that packet open. The requester continues it at its next grant.
- A single-requester system with continuous traffic still passes through IDLE after every release.

## Timing
- Arbitration latency: a request first seen in IDLE at cycle t receives a grant at t+1. Its first transfer happens at t+1 at the earliest.
- Throughput: one byte per cycle while the owner is valid and the FIFO is not full.
- Every grant is followed by exactly one IDLE bubble cycle before the next grant.
- fifo_full is sampled in the same cycle as the write. A write is never issued while fifo_full=1.
- Reset during OWN drops the grant immediately. The partially written packet remains in the FIFO.
- Outputs during reset: grant=0, req_ready=0, fifo_wr=0, fifo_w_data=0.

## Configuration
- UART_TX_ARB_STATS_EN defined:
  - Adds output stat_bytes (N_REQ*16). Each 16-bit slice counts accepted bytes for its requester and wraps at 0xFFFF.
  - Adds output stat_drops (16). It counts cycles in OWN with req_valid[g] & fifo_full.
  - All counters reset to 0.
- UART_TX_ARB_STATS_EN undefined: these ports and counters do not exist, and arbitration behaviour is identical.

## Structure
- Shared package uart_pkg holds:
  - the state encoding, ST_IDLE=1'b0 and ST_OWN=1'b1
  - UART_BYTE_W=8
  - the default MAX_BURST constant
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req (N_REQ), ptr ($clog2(N_REQ)).
  - Outputs: onehot (N_REQ) and idx.
  - Used only in IDLE.

## Test plan
- **Single packet:** N_REQ=2, req0 sends 0x41,0x42,0x43 (last on 0x43) with the FIFO empty. Expect grant=01 at t+1, fifo_wr on three consecutive cycles with data 0x41..0x43, then grant=00.
- **Contention:** req0 and req1 both valid with 2-byte packets from reset. Expect req0 served first, a one-cycle IDLE bubble, then req1. Next round: req0 first again, because rr_ptr has wrapped to 0.
- **FIFO full stall:** fifo_full=1 for 3 cycles mid-packet. Expect fifo_wr=0 and req_ready=0 during those cycles, grant held, and no byte lost or duplicated once full drops.
- **Burst limit:** MAX_BURST=4, req0 streams 6 bytes with last only on byte 6 while req1 waits. Expect release after byte 4, req1 served next, then req0's remaining 2 bytes.
- **Reset mid-packet:** assert rst after 2 of 5 bytes. Expect grant=00 and fifo_wr=0 immediately. After release, the first grant goes to the lowest valid index.
- **Stats, with UART_TX_ARB_STATS_EN:** after the contention test, expect stat_bytes slice0=2, slice1=2 and stat_drops=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: state encoding, byte width,
// default burst limit and an index-width helper.
package uart_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   localparam int UART_BYTE_W    = 8;
   localparam int UART_MAX_BURST = 16;

   // Width of an index into n requesters (never zero).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr, wrapping modulo N_REQ.
module rr_pick
   import uart_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int PW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [PW-1:0]    idx
);

   int   j;
   logic found;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = PW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of a UART TX FIFO write port; one packet (or
// MAX_BURST bytes) per grant. Optional counters under UART_TX_ARB_STATS_EN.
//
// Handshake: a byte moves from requester g to the FIFO in the cycle where
// grant[g] & req_valid[g] & ~fifo_full; req_ready[g] and fifo_wr are both
// high in exactly that cycle and the requester must hold data until then.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int B         = UART_BYTE_W,
   parameter int MAX_BURST = UART_MAX_BURST
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*B-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 fifo_wr,
   output logic [B-1:0]         fifo_w_data,
   input  logic                 fifo_full,
`ifdef UART_TX_ARB_STATS_EN
   output logic [N_REQ*16-1:0]  stat_bytes,
   output logic [15:0]          stat_drops,
`endif
   output arb_state_e           dbg_state
);

   localparam int PW = idx_w(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_e       state, state_nxt;
   logic [N_REQ-1:0] grant_nxt, pick_onehot, xfer;
   logic [PW-1:0]    owner, owner_nxt, rr_ptr, rr_ptr_nxt, pick_idx;
   logic [CW-1:0]    burst_cnt, burst_cnt_nxt;
   logic             release_now;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // Grant is zero in IDLE and during reset, so the datapath goes quiet there.
   assign xfer      = grant & req_valid & {N_REQ{~fifo_full}};
   assign req_ready = xfer;
   assign fifo_wr   = |xfer;
   assign dbg_state = state;

   always_comb begin
      fifo_w_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (xfer[i]) fifo_w_data = fifo_w_data | req_data[i*B +: B];
      end
   end

   assign release_now = fifo_wr &
                        ((|(xfer & req_last)) | (burst_cnt == CW'(MAX_BURST - 1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         owner     <= owner_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      owner_nxt     = owner;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      case (state)
         ST_IDLE: begin
            if (|req_valid) begin
               state_nxt     = ST_OWN;
               grant_nxt     = pick_onehot;
               owner_nxt     = pick_idx;
               burst_cnt_nxt = '0;
            end
         end
         ST_OWN: begin
            if (fifo_wr) burst_cnt_nxt = burst_cnt + CW'(1);
            if (release_now) begin
               state_nxt  = ST_IDLE;
               grant_nxt  = '0;
               rr_ptr_nxt = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

`ifdef UART_TX_ARB_STATS_EN
   // A drop cycle is an owner with data held back by a full FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_bytes <= '0;
         stat_drops <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (xfer[i]) stat_bytes[i*16 +: 16] <= stat_bytes[i*16 +: 16] + 16'd1;
         end
         if ((state == ST_OWN) && (|(grant & req_valid)) && fifo_full)
            stat_drops <= stat_drops + 16'd1;
      end
   end
`endif

endmodule
